// File: rtl/bus_arbiter_2dev.sv
// bus_arbiter_2dev: round-robin two-device bus arbiter with hold limit and cross-capture of bus words
module bus_arbiter_2dev #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_1,
    input  logic         req_2,
    input  logic         last_1,
    input  logic         last_2,
    input  logic [N-1:0] bus,
    output logic         select,
    output logic         grant_1,
    output logic         grant_2,
    output logic         bus_valid,
    output logic [N-1:0] rx_data_1,
    output logic         rx_valid_1,
    output logic [N-1:0] rx_data_2,
    output logic         rx_valid_2
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

    state_t        state, nxt;
    logic [HW-1:0] hold_cnt;
    logic          ptr;
    logic          exit_1, exit_2, exit_cur;

    always_comb begin
        exit_1   = last_1 | ~req_1 | (hold_cnt == HMAX && req_2);
        exit_2   = last_2 | ~req_2 | (hold_cnt == HMAX && req_1);
        exit_cur = (state == GNT1) ? exit_1 : (state == GNT2) ? exit_2 : 1'b0;
        nxt      = IDLE;
        case (state)
            IDLE: nxt = (req_1 && (!req_2 || !ptr)) ? GNT1 : req_2 ? GNT2 : IDLE;
            GNT1: nxt = !exit_1 ? GNT1 : req_2 ? GNT2 : (req_1 && !last_1) ? GNT1 : IDLE;
            GNT2: nxt = !exit_2 ? GNT2 : req_1 ? GNT1 : (req_2 && !last_2) ? GNT2 : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            select     <= 1'b0;
            grant_1    <= 1'b0;
            grant_2    <= 1'b0;
            bus_valid  <= 1'b0;
            hold_cnt   <= '0;
            ptr        <= 1'b0;
            rx_data_1  <= '0;
            rx_data_2  <= '0;
            rx_valid_1 <= 1'b0;
            rx_valid_2 <= 1'b0;
        end else begin
            state     <= nxt;
            grant_1   <= nxt == GNT1;
            grant_2   <= nxt == GNT2;
            bus_valid <= nxt != IDLE;
            select    <= (nxt == GNT2) ? 1'b1 : (nxt == GNT1) ? 1'b0 : select;
            // any exit, even one that re-grants the same device, restarts the hold window
            hold_cnt  <= (exit_cur || nxt != state) ? '0 : (hold_cnt == HMAX) ? hold_cnt : hold_cnt + 1'b1;
            if (exit_cur)
                ptr <= state == GNT1;
            rx_valid_2 <= state == GNT1;
            rx_valid_1 <= state == GNT2;
            if (state == GNT1)
                rx_data_2 <= bus;
            if (state == GNT2)
                rx_data_1 <= bus;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_2dev.sv
// tb_bus_arbiter_2dev: directed vectors feed a scoreboard queue; a monitor checks each registered response
module tb_bus_arbiter_2dev;
    logic       clk = 0, rst = 1, req_1 = 0, req_2 = 0, last_1 = 0, last_2 = 0;
    logic [7:0] bus = 0;
    logic       select, grant_1, grant_2, bus_valid, rx_valid_1, rx_valid_2;
    logic [7:0] rx_data_1, rx_data_2;

    typedef struct {
        string       nm;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    bus_arbiter_2dev #(.N(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req_1(req_1), .req_2(req_2), .last_1(last_1), .last_2(last_2),
        .bus(bus), .select(select), .grant_1(grant_1), .grant_2(grant_2), .bus_valid(bus_valid),
        .rx_data_1(rx_data_1), .rx_valid_1(rx_valid_1), .rx_data_2(rx_data_2), .rx_valid_2(rx_valid_2)
    );

    always #5 clk = ~clk;

    // expected fields: {bus_valid, grant_1, grant_2, select, rx_valid_1, rx_valid_2, rx_data_1, rx_data_2}
    task automatic s(input string nm, input logic r, r1, r2, l1, l2, input logic [7:0] b,
                     input logic g1, g2, sel, rv1, rv2, input logic [7:0] d1, d2);
        exp_t e;
        @(negedge clk);
        rst = r; req_1 = r1; req_2 = r2; last_1 = l1; last_2 = l2; bus = b;
        e.nm = nm;
        e.v  = {g1 | g2, g1, g2, sel, rv1, rv2, d1, d2};
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t e;
                logic [21:0] act;
                e   = q.pop_front();
                act = {bus_valid, grant_1, grant_2, select, rx_valid_1, rx_valid_2, rx_data_1, rx_data_2};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: got bv/g1/g2/sel/rv1/rv2/d1/d2=%b %b %b %b %b %b %h %h want %b %b %b %b %b %b %h %h",
                             e.nm, act[21], act[20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                             e.v[21], e.v[20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:8], e.v[7:0]);
                end
            end
        end
    end

    initial begin
        s("rst0",         1,1,1,0,0,8'h00, 0,0,0,0,0,8'h00,8'h00);
        s("rst1",         1,1,1,0,0,8'h00, 0,0,0,0,0,8'h00,8'h00);
        s("first_g1",     0,1,1,0,0,8'h00, 1,0,0,0,0,8'h00,8'h00);
        s("g1_last",      0,1,0,1,0,8'h11, 0,0,0,0,1,8'h00,8'h11);
        s("idle",         0,0,0,0,0,8'h00, 0,0,0,0,0,8'h00,8'h11);
        s("st_g1",        0,1,0,0,0,8'h00, 1,0,0,0,0,8'h00,8'h11);
        s("st_b1",        0,1,0,0,0,8'hA5, 1,0,0,0,1,8'h00,8'hA5);
        s("st_b2",        0,1,0,0,0,8'h3C, 1,0,0,0,1,8'h00,8'h3C);
        s("st_b3",        0,1,0,1,0,8'h7E, 0,0,0,0,1,8'h00,8'h7E);
        s("st_idle",      0,0,0,0,0,8'h00, 0,0,0,0,0,8'h00,8'h7E);
        s("rr_g2",        0,1,1,0,0,8'h00, 0,1,1,0,0,8'h00,8'h7E);
        s("rr_g2b",       0,1,1,0,0,8'h21, 0,1,1,1,0,8'h21,8'h7E);
        s("rr_g1",        0,1,1,0,1,8'h22, 1,0,0,1,0,8'h22,8'h7E);
        s("rr_g1b",       0,1,1,0,0,8'h23, 1,0,0,0,1,8'h22,8'h23);
        s("rr_g2c",       0,1,1,1,0,8'h24, 0,1,1,0,1,8'h22,8'h24);
        s("rr_g2d",       0,1,1,0,0,8'h25, 0,1,1,1,0,8'h25,8'h24);
        s("lastreq_idle", 0,0,1,0,1,8'h26, 0,0,1,1,0,8'h26,8'h24);
        s("lastreq_g2",   0,0,1,0,0,8'h00, 0,1,1,0,0,8'h26,8'h24);
        s("drop_g2",      0,0,0,0,0,8'h27, 0,0,1,1,0,8'h27,8'h24);
        s("pre_g1",       0,1,0,0,0,8'h00, 1,0,0,0,0,8'h27,8'h24);
        s("pre_h1",       0,1,1,0,0,8'h31, 1,0,0,0,1,8'h27,8'h31);
        s("pre_h2",       0,1,1,0,0,8'h32, 1,0,0,0,1,8'h27,8'h32);
        s("pre_h3",       0,1,1,0,0,8'h33, 1,0,0,0,1,8'h27,8'h33);
        s("preempt",      0,1,1,0,0,8'h34, 0,1,1,0,1,8'h27,8'h34);
        s("back_g1",      0,1,0,0,0,8'h35, 1,0,0,1,0,8'h35,8'h34);
        for (int i = 0; i < 5; i++)
            s("hold_sat", 0,1,0,0,0,8'h40 + 8'(i), 1,0,0,0,1,8'h35,8'h40 + 8'(i));
        s("sat_preempt",  0,1,1,0,0,8'h45, 0,1,1,0,1,8'h35,8'h45);
        s("g2_beat",      0,0,1,0,0,8'h50, 0,1,1,1,0,8'h50,8'h45);
        s("mid_rst",      1,0,1,0,0,8'h51, 0,0,0,0,0,8'h00,8'h00);
        s("post_rst",     0,0,0,1,1,8'h00, 0,0,0,0,0,8'h00,8'h00);
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending responses want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
